// File: rtl/multi_mode_ff_reg.sv
// multi_mode_ff_reg: WIDTH-bit flip-flop bank whose per-cycle update rule
// (hold, D, T, JK, SR, shift left/right, synchronous clear) is chosen by mode.
// Also provides q_n, a one-cycle "changed" pulse and a sticky SR-conflict flag.
//
// Optional build feature: define MULTI_MODE_FF_SR_CHECK_EN to enable the
// SR-conflict detector (sr_err / err_clr). Without it sr_err is tied low,
// err_clr is ignored, and q behaves identically.
//
// Handshake: none. Every input is sampled on each rising clk edge. en=0
// behaves as HOLD for q, changed and sr_err, but err_clr still acts.

module multi_mode_ff_reg #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             err_clr,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_n,
    output logic             changed,
    output logic             sr_err
);

    localparam logic [2:0] MODE_HOLD = 3'b000;
    localparam logic [2:0] MODE_D    = 3'b001;
    localparam logic [2:0] MODE_T    = 3'b010;
    localparam logic [2:0] MODE_JK   = 3'b011;
    localparam logic [2:0] MODE_SR   = 3'b100;
    localparam logic [2:0] MODE_SHL  = 3'b101;
    localparam logic [2:0] MODE_SHR  = 3'b110;
    localparam logic [2:0] MODE_CLR  = 3'b111;

    // Candidate next values, one per flip-flop type.
    logic [WIDTH-1:0] d_next;
    logic [WIDTH-1:0] t_next;
    logic [WIDTH-1:0] jk_next;
    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] shl_next;
    logic [WIDTH-1:0] shr_next;
    logic [WIDTH-1:0] q_next;

    // Per-mode next-state equations, all evaluated in parallel.
    always_comb begin
        d_next   = a;
        t_next   = q ^ a;
        // JK: set where j&~k, clear where k&~j, toggle where both, hold otherwise.
        jk_next  = (a & ~q) | (~b & q);
        // SR: s=r=1 is illegal and holds, same as s=r=0.
        sr_next  = (a & ~b) | (q & ~(a ^ b));
        shl_next = {q[WIDTH-2:0], a[0]};
        shr_next = {a[0], q[WIDTH-1:1]};
    end

    // Mode selection; en=0 forces hold so changed naturally drops to 0.
    always_comb begin
        q_next = q;
        if (en) begin
            case (mode)
                MODE_HOLD: q_next = q;
                MODE_D:    q_next = d_next;
                MODE_T:    q_next = t_next;
                MODE_JK:   q_next = jk_next;
                MODE_SR:   q_next = sr_next;
                MODE_SHL:  q_next = shl_next;
                MODE_SHR:  q_next = shr_next;
                MODE_CLR:  q_next = RESET_VAL;
                default:   q_next = q;
            endcase
        end
    end

    // State register and change-detect pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q       <= RESET_VAL;
            changed <= 1'b0;
        end else begin
            q       <= q_next;
            changed <= (q_next != q);
        end
    end

    // Complement output follows q with no extra register.
    assign q_n = ~q;

`ifdef MULTI_MODE_FF_SR_CHECK_EN
    logic sr_conflict;
    assign sr_conflict = en && (mode == MODE_SR) && (|(a & b));

    // Sticky conflict flag: a new conflict beats a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_err <= 1'b0;
        end else if (sr_conflict) begin
            sr_err <= 1'b1;
        end else if (err_clr) begin
            sr_err <= 1'b0;
        end
    end
`else
    // Detector absent: flag is constant low and err_clr has no effect.
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign sr_err         = 1'b0;
`endif

endmodule

// File: tb/tb_multi_mode_ff_reg.sv
// Directed bench for multi_mode_ff_reg (WIDTH=8, RESET_VAL=8'h00).
// Expected sr_err values depend on MULTI_MODE_FF_SR_CHECK_EN.

module tb_multi_mode_ff_reg;

    localparam int WIDTH = 8;

    localparam logic [2:0] M_HOLD = 3'b000;
    localparam logic [2:0] M_D    = 3'b001;
    localparam logic [2:0] M_T    = 3'b010;
    localparam logic [2:0] M_JK   = 3'b011;
    localparam logic [2:0] M_SR   = 3'b100;
    localparam logic [2:0] M_SHL  = 3'b101;
    localparam logic [2:0] M_SHR  = 3'b110;
    localparam logic [2:0] M_CLR  = 3'b111;

`ifdef MULTI_MODE_FF_SR_CHECK_EN
    localparam logic SR_ON = 1'b1;
`else
    localparam logic SR_ON = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             err_clr;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_n;
    logic             changed;
    logic             sr_err;

    int vectors;
    int miscompares;

    multi_mode_ff_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .mode    (mode),
        .a       (a),
        .b       (b),
        .err_clr (err_clr),
        .q       (q),
        .q_n     (q_n),
        .changed (changed),
        .sr_err  (sr_err)
    );

    // Clock: 10 ns period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one edge worth of inputs at the falling edge, then sample 1 ns
    // after the following rising edge.
    task automatic apply(input logic e, input logic [2:0] m,
                         input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic ec);
        @(negedge clk);
        en      = e;
        mode    = m;
        a       = va;
        b       = vb;
        err_clr = ec;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        // Reset held from time 0.
        #2;
        vectors++;
        if (q !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_q: got %h expected %h", q, 8'h00);
        end
        vectors++;
        if (q_n !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_q_n: got %h expected %h", q_n, 8'hFF);
        end
        vectors++;
        if (changed !== 1'b0 || sr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_flags: got changed=%b sr_err=%b expected 0 0", changed, sr_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, M_D, 8'h3C, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h3C || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_preload: got q=%h changed=%b expected 3c 1", q, changed);
        end
        // Asynchronous reset between edges, no clock edge before checking.
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if (q !== 8'h00 || q_n !== 8'hFF || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: got q=%h q_n=%h changed=%b expected 00 ff 0", q, q_n, changed);
        end
        @(negedge clk);
        rst_n = 1'b1;
        apply(1'b1, M_D, 8'h11, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h11 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_first_edge: got q=%h changed=%b expected 11 1", q, changed);
        end
    endtask

    task automatic test_d_hold();
        apply(1'b1, M_D, 8'hA5, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'hA5 || q_n !== 8'h5A || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL d_load: got q=%h q_n=%h changed=%b expected a5 5a 1", q, q_n, changed);
        end
        apply(1'b1, M_HOLD, 8'hFF, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'hA5 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL hold: got q=%h changed=%b expected a5 0", q, changed);
        end
        apply(1'b0, M_CLR, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'hA5 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL en_low_clr: got q=%h changed=%b expected a5 0", q, changed);
        end
        apply(1'b1, M_D, 8'hA5, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'hA5 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL d_same_value: got q=%h changed=%b expected a5 0", q, changed);
        end
    endtask

    task automatic test_toggle();
        apply(1'b1, M_T, 8'hFF, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h5A || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL t_all: got q=%h changed=%b expected 5a 1", q, changed);
        end
        apply(1'b1, M_T, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h5A || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL t_none: got q=%h changed=%b expected 5a 0", q, changed);
        end
        apply(1'b1, M_T, 8'h0F, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h55 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL t_low_nibble: got q=%h changed=%b expected 55 1", q, changed);
        end
    endtask

    task automatic test_jk();
        apply(1'b1, M_D, 8'h0F, 8'h00, 1'b0);
        apply(1'b1, M_JK, 8'hF0, 8'h3C, 1'b0);
        vectors++;
        if (q !== 8'hF3 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL jk: got q=%h changed=%b expected f3 1", q, changed);
        end
        apply(1'b1, M_JK, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'hF3 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL jk_hold: got q=%h changed=%b expected f3 0", q, changed);
        end
    endtask

    task automatic test_sr();
        apply(1'b1, M_CLR, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h00 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL sr_preclear: got q=%h changed=%b expected 00 1", q, changed);
        end
        apply(1'b1, M_SR, 8'h81, 8'h01, 1'b0);
        vectors++;
        if (q !== 8'h80 || sr_err !== SR_ON) begin
            miscompares++;
            $display("FAIL sr_conflict: got q=%h sr_err=%b expected 80 %b", q, sr_err, SR_ON);
        end
        apply(1'b1, M_SR, 8'h81, 8'h01, 1'b1);
        vectors++;
        if (q !== 8'h80 || changed !== 1'b0 || sr_err !== SR_ON) begin
            miscompares++;
            $display("FAIL sr_set_beats_clr: got q=%h changed=%b sr_err=%b expected 80 0 %b",
                     q, changed, sr_err, SR_ON);
        end
        apply(1'b1, M_HOLD, 8'h00, 8'h00, 1'b0);
        vectors++;
        if (sr_err !== SR_ON) begin
            miscompares++;
            $display("FAIL sr_sticky: got sr_err=%b expected %b", sr_err, SR_ON);
        end
        apply(1'b1, M_HOLD, 8'h00, 8'h00, 1'b1);
        vectors++;
        if (sr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sr_clear: got sr_err=%b expected 0", sr_err);
        end
        // Conflict with en=0 must not raise the flag.
        apply(1'b0, M_SR, 8'hFF, 8'hFF, 1'b0);
        vectors++;
        if (sr_err !== 1'b0 || q !== 8'h80) begin
            miscompares++;
            $display("FAIL sr_en_low: got q=%h sr_err=%b expected 80 0", q, sr_err);
        end
        // Plain set/clear lanes with no conflict.
        apply(1'b1, M_SR, 8'h06, 8'h80, 1'b0);
        vectors++;
        if (q !== 8'h06 || sr_err !== 1'b0) begin
            miscompares++;
            $display("FAIL sr_set_reset: got q=%h sr_err=%b expected 06 0", q, sr_err);
        end
        apply(1'b1, M_D, 8'h80, 8'h00, 1'b0);
    endtask

    task automatic test_shift_clear();
        apply(1'b1, M_SHL, 8'h01, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'h01 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL shl: got q=%h changed=%b expected 01 1", q, changed);
        end
        apply(1'b1, M_SHR, 8'h01, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'h80 || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL shr: got q=%h changed=%b expected 80 1", q, changed);
        end
        apply(1'b1, M_SHR, 8'hFE, 8'h00, 1'b0);
        vectors++;
        if (q !== 8'h40) begin
            miscompares++;
            $display("FAIL shr_zero_in: got q=%h expected 40", q);
        end
        apply(1'b1, M_CLR, 8'hFF, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'h00 || q_n !== 8'hFF || changed !== 1'b1) begin
            miscompares++;
            $display("FAIL clr: got q=%h q_n=%h changed=%b expected 00 ff 1", q, q_n, changed);
        end
        apply(1'b1, M_CLR, 8'hFF, 8'hFF, 1'b0);
        vectors++;
        if (q !== 8'h00 || changed !== 1'b0) begin
            miscompares++;
            $display("FAIL clr_again: got q=%h changed=%b expected 00 0", q, changed);
        end
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] vals [4];
        vals[0] = 8'h01;
        vals[1] = 8'h02;
        vals[2] = 8'h03;
        vals[3] = 8'hC3;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, M_D, vals[i], 8'h00, 1'b0);
            vectors++;
            if (q !== vals[i] || changed !== 1'b1) begin
                miscompares++;
                $display("FAIL b2b_%0d: got q=%h changed=%b expected %h 1", i, q, changed, vals[i]);
            end
        end
        apply(1'b1, M_D, 8'hC3, 8'h00, 1'b0);
        vectors++;
        if (changed !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_end: got changed=%b expected 0", changed);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        en          = 1'b0;
        mode        = M_HOLD;
        a           = '0;
        b           = '0;
        err_clr     = 1'b0;

        test_reset();
        test_d_hold();
        test_toggle();
        test_jk();
        test_sr();
        test_shift_clear();
        test_back_to_back();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
